alu_iter: RTL
=============

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, datapath width; legal values are powers of two >= 4.
REQ-002 SHALL have localparam OP_W = 4, opcode width, and SHAMT_W = $clog2(DATA_W), shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 operand_a, operand_b  input  DATA_W each  operands.
REQ-008 op  input  OP_W  operation code.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 alu_result  output  DATA_W  registered result.
REQ-012 zero_flag, positive_flag, carry_flag, signed_overflow, illegal_op  output  1 each  registered flags.

Function
REQ-013 Request accepted on a rising edge with in_valid && in_ready; operands and op captured then, later input changes ignored.
REQ-014 in_ready SHALL be 1 only in state IDLE; one operation outstanding at a time.
REQ-015 FSM states IDLE, BUSY, DONE: IDLE->BUSY on accept; BUSY->DONE when the iteration counter expires; DONE->IDLE on out_valid && out_ready.
REQ-016 out_valid SHALL be 1 exactly in DONE; alu_result and all flags SHALL hold stable while out_valid && !out_ready.
REQ-017 Opcodes: 0000 ADD, 0001 SUB, 0010/0011 AND, 0100 OR, 0101 XOR, 0110/0111 NOT a, 1000 SHL, 1001 SHR logical, 1010 SAR, 1011 MUL (low half, unsigned), 1100-1111 reserved.
REQ-018 ADD = a+b; SUB = a+~b+1; carry_flag = bit DATA_W of that sum (SUB: 1 means no borrow); signed_overflow = operands' effective signs equal and result sign differs.
REQ-019 AND/OR/XOR/NOT: carry_flag = 0, signed_overflow = 0.
REQ-020 Shift amount k = operand_b[SHAMT_W-1:0]; shifts SHALL iterate one bit per cycle.
REQ-021 Shifts: carry_flag = last bit shifted out (0 when k = 0); signed_overflow = 0; SAR replicates a's MSB.
REQ-022 MUL SHALL be shift-add, one multiplier bit per cycle, 2*DATA_W-bit product; alu_result = low DATA_W bits; carry_flag = signed_overflow = (high half != 0).
REQ-023 Latency, accept edge to out_valid high: single-cycle ops and reserved = 1 cycle; shifts = 1+k cycles; MUL = DATA_W cycles.
REQ-024 Reserved opcodes: alu_result = 0, illegal_op = 1, carry_flag = signed_overflow = 0; illegal_op = 0 for all legal opcodes.
REQ-025 For all ops zero_flag = (alu_result == 0) and positive_flag = ~alu_result[DATA_W-1].
REQ-026 in_valid asserted while not in IDLE SHALL NOT be accepted; requester holds the request.
REQ-027 DONE->IDLE and a new accept SHALL NOT occur on the same edge; minimum issue interval = latency + 1 cycle.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, in_ready = 1 after release, out_valid = 0, alu_result = 0, zero_flag = 1, positive_flag = 1, carry_flag = 0, signed_overflow = 0, illegal_op = 0.
REQ-029 Reset during BUSY or DONE SHALL abort the operation with no result delivered.

Verification (DATA_W = 8)
REQ-030 ADD 0x7F+0x01 -> one cycle later out_valid, result 0x80, signed_overflow 1, carry 0, positive 0, zero 0.
REQ-031 SUB 0x05-0x05 -> result 0x00, zero 1, carry 1, signed_overflow 0; SUB 0x00-0x01 -> 0xFF, carry 0.
REQ-032 MUL 0x10*0x20 -> out_valid 8 cycles after accept, result 0x00, zero 1, carry 1, signed_overflow 1; MUL 0x0F*0x11 -> 0xFF, carry 0.
REQ-033 SAR 0x80 by 3 -> 0xF0, carry 0, latency 4; SHR 0x81 by 1 -> 0x40, carry 1; SHL 0x55 by 0 -> 0x55, carry 0, latency 1.
REQ-034 out_ready held low 5 cycles in DONE -> result and flags unchanged, in_ready 0, new in_valid ignored; out_ready high -> IDLE next cycle.
REQ-035 rst_n low mid-MUL (cycle 4) -> out_valid 0 immediately, reset values on outputs, in_ready 1 after release; op 1101 -> result 0, illegal_op 1.

Source files
------------

// File: rtl/alu_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_iter_if
// Description : Request/response bundle for the iterative ALU.
//               Request side : in_valid, in_ready, operand_a, operand_b, op
//               Response side: out_valid, out_ready, alu_result and flags
//               (zero_flag, positive_flag, carry_flag, signed_overflow,
//               illegal_op).
//               master = requester/consumer, slave = ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_iter_if #(
  parameter int DATA_W = 8
);
  localparam int OP_W = 4;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic [OP_W-1:0]   op;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_result;
  logic              zero_flag;
  logic              positive_flag;
  logic              carry_flag;
  logic              signed_overflow;
  logic              illegal_op;

  modport master (
    output in_valid, operand_a, operand_b, op, out_ready,
    input  in_ready, out_valid, alu_result, zero_flag, positive_flag,
           carry_flag, signed_overflow, illegal_op
  );

  modport slave (
    input  in_valid, operand_a, operand_b, op, out_ready,
    output in_ready, out_valid, alu_result, zero_flag, positive_flag,
           carry_flag, signed_overflow, illegal_op
  );
endinterface
`default_nettype wire

// File: rtl/alu_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_iter
// Description : Iterative ALU with valid/ready handshakes. Logic/arith ops
//               finish in one cycle, shifts step one bit per cycle, MUL is a
//               shift-add over DATA_W cycles. One operation in flight.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - alu_iter_if.slave (request, response, result, flags)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_iter #(
  parameter int DATA_W = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_iter_if.slave bus
);
  localparam int OP_W    = 4;
  localparam int SHAMT_W = $clog2(DATA_W);

  localparam logic [OP_W-1:0] c_OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] c_OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] c_OP_SHL = 4'b1000;
  localparam logic [OP_W-1:0] c_OP_SHR = 4'b1001;
  localparam logic [OP_W-1:0] c_OP_SAR = 4'b1010;
  localparam logic [OP_W-1:0] c_OP_MUL = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [OP_W-1:0]     r_op;
  logic [DATA_W-1:0]   r_a;     // operand a / shift register
  logic [DATA_W-1:0]   r_hi;    // product high half
  logic [DATA_W-1:0]   r_lo;    // operand b, then multiplier / product low half
  logic                r_c;     // last bit shifted out
  logic [SHAMT_W-1:0]  r_cnt;   // remaining BUSY cycles before finishing

  logic [DATA_W-1:0]   r_result;
  logic                r_zero, r_pos, r_carry, r_ovf, r_ill;

  logic                w_accept;
  logic                w_is_shift;
  logic [DATA_W-1:0]   w_bx;
  logic [DATA_W:0]     w_addsum;
  logic [DATA_W:0]     w_mul_sum;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_res;
  logic                w_cf, w_ov, w_ill;

  assign w_accept   = bus.in_valid && (r_state == S_IDLE);
  assign w_is_shift = (bus.op == c_OP_SHL) || (bus.op == c_OP_SHR) || (bus.op == c_OP_SAR);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)       w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == '0)    w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready)  w_state_nxt = S_IDLE;
      default:                     w_state_nxt = S_IDLE;
    endcase
  end

  // Result of the final BUSY cycle. For MUL the last multiplier bit is
  // folded in here, so the product completes in exactly DATA_W cycles.
  always_comb begin
    w_res     = '0;
    w_cf      = 1'b0;
    w_ov      = 1'b0;
    w_ill     = 1'b0;
    w_bx      = (r_op == c_OP_SUB) ? ~r_lo : r_lo;
    w_addsum  = {1'b0, r_a} + {1'b0, w_bx} + {{DATA_W{1'b0}}, (r_op == c_OP_SUB)};
    w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    w_prod    = {w_mul_sum, r_lo[DATA_W-1:1]};
    case (r_op)
      c_OP_ADD, c_OP_SUB: begin
        w_res = w_addsum[DATA_W-1:0];
        w_cf  = w_addsum[DATA_W];
        w_ov  = (r_a[DATA_W-1] == w_bx[DATA_W-1]) &&
                (w_addsum[DATA_W-1] != r_a[DATA_W-1]);
      end
      4'b0010, 4'b0011: w_res = r_a & r_lo;
      4'b0100:          w_res = r_a | r_lo;
      4'b0101:          w_res = r_a ^ r_lo;
      4'b0110, 4'b0111: w_res = ~r_a;
      c_OP_SHL, c_OP_SHR, c_OP_SAR: begin
        w_res = r_a;
        w_cf  = r_c;
      end
      c_OP_MUL: begin
        w_res = w_prod[DATA_W-1:0];
        w_cf  = |w_prod[2*DATA_W-1:DATA_W];
        w_ov  = |w_prod[2*DATA_W-1:DATA_W];
      end
      default: w_ill = 1'b1;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_pos    <= 1'b1;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_ill    <= 1'b0;
    end else if (w_accept) begin
      r_op <= bus.op;
      r_a  <= bus.operand_a;
      r_lo <= bus.operand_b;
      r_hi <= '0;
      r_c  <= 1'b0;
      if (bus.op == c_OP_MUL) r_cnt <= SHAMT_W'(DATA_W - 1);
      else if (w_is_shift)    r_cnt <= bus.operand_b[SHAMT_W-1:0];
      else                    r_cnt <= '0;
    end else if (r_state == S_BUSY) begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
        case (r_op)
          c_OP_SHL: begin r_a <= {r_a[DATA_W-2:0], 1'b0};         r_c <= r_a[DATA_W-1]; end
          c_OP_SHR: begin r_a <= {1'b0, r_a[DATA_W-1:1]};         r_c <= r_a[0];        end
          c_OP_SAR: begin r_a <= {r_a[DATA_W-1], r_a[DATA_W-1:1]}; r_c <= r_a[0];       end
          c_OP_MUL: {r_hi, r_lo} <= w_prod;
          default: ;
        endcase
      end else begin
        r_result <= w_res;
        r_zero   <= (w_res == '0);
        r_pos    <= ~w_res[DATA_W-1];
        r_carry  <= w_cf;
        r_ovf    <= w_ov;
        r_ill    <= w_ill;
      end
    end
  end

  assign bus.in_ready        = (r_state == S_IDLE);
  assign bus.out_valid       = (r_state == S_DONE);
  assign bus.alu_result      = r_result;
  assign bus.zero_flag       = r_zero;
  assign bus.positive_flag   = r_pos;
  assign bus.carry_flag      = r_carry;
  assign bus.signed_overflow = r_ovf;
  assign bus.illegal_op      = r_ill;
endmodule
`default_nettype wire
